// File: rtl/cronometro_pkg.sv
// Shared types, constants and BCD helpers for the countdown timer.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_00 = 8'h00;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } count_t;

    // True when a single BCD digit is a legal decimal digit.
    function automatic logic bcd_digit_ok(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

    // True when both digits of a BCD byte are legal.
    function automatic logic bcd_byte_ok(input logic [7:0] v);
        return bcd_digit_ok(v[7:4]) && bcd_digit_ok(v[3:0]);
    endfunction

endpackage

// File: rtl/bcd_dec_2d.sv
// Combinational two-digit BCD decrement with wrap and borrow-out.
module bcd_dec_2d
    import cronometro_pkg::*;
(
    input  logic [7:0] value_i,
    input  logic [7:0] wrap_i,
    output logic [7:0] value_o,
    output logic       borrow_o
);

    // Decrement one BCD field; 00 wraps to wrap_i and borrows from the next field.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        value_o  = value_i;
        borrow_o = 1'b0;
        if (value_i == BCD_00) begin
            value_o  = wrap_i;
            borrow_o = 1'b1;
        end else if (value_i[3:0] == 4'd0) begin
            value_o = {value_i[7:4] - 4'd1, 4'd9};
        end else begin
            value_o = {value_i[7:4], value_i[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/cronometro_regresivo.sv
// BCD HH:MM:SS countdown timer with expiry flag.
// Optional build macro CRONO_BCD_CLAMP_EN: clamp out-of-range load fields
// instead of rejecting the whole load.
module cronometro_regresivo
    import cronometro_pkg::*;
#(
    parameter logic [7:0] HH_MAX      = 8'h23,
    parameter logic       TICK_ACTIVE = 1'b1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       fin_crono,
    output logic       activo
);

    state_e state_q, state_d;
    count_t cnt_q, cnt_d;
    logic   fin_q, fin_d;
    logic   activo_q, activo_d;

    count_t dec_cnt;
    logic   ss_borrow, mm_borrow, hh_borrow;
    logic   cnt_nonzero;
    logic   tick;
    logic   load_ok;
    count_t load_val;

    assign tick = (tick_1hz == TICK_ACTIVE);

    bcd_dec_2d u_dec_ss (
        .value_i  (cnt_q.ss),
        .wrap_i   (BCD_59),
        .value_o  (dec_cnt.ss),
        .borrow_o (ss_borrow)
    );

    logic [7:0] mm_dec, hh_dec;

    bcd_dec_2d u_dec_mm (
        .value_i  (cnt_q.mm),
        .wrap_i   (BCD_59),
        .value_o  (mm_dec),
        .borrow_o (mm_borrow)
    );

    // Hours never wrap in practice: a zero count is never decremented.
    bcd_dec_2d u_dec_hh (
        .value_i  (cnt_q.hh),
        .wrap_i   (BCD_00),
        .value_o  (hh_dec),
        .borrow_o (hh_borrow)
    );

    // Ripple the borrows: minutes move only on a seconds borrow, hours on both.
    always_comb begin
        dec_cnt.mm = ss_borrow ? mm_dec : cnt_q.mm;
        dec_cnt.hh = (ss_borrow && mm_borrow) ? hh_dec : cnt_q.hh;
    end

    // All three fields read 00 exactly when every decrementer would borrow.
    assign cnt_nonzero = !(ss_borrow && mm_borrow && hh_borrow);

`ifdef CRONO_BCD_CLAMP_EN
    function automatic logic [7:0] clamp_ms(input logic [7:0] v);
        if (!bcd_byte_ok(v) || v > BCD_59) return BCD_59;
        return v;
    endfunction

    function automatic logic [7:0] clamp_hh(input logic [7:0] v);
        if (!bcd_byte_ok(v) || v > HH_MAX) return HH_MAX;
        return v;
    endfunction

    // Every load is accepted; each field is clamped on its own.
    always_comb begin
        load_ok     = 1'b1;
        load_val.hh = clamp_hh(hh_in);
        load_val.mm = clamp_ms(mm_in);
        load_val.ss = clamp_ms(ss_in);
    end
`else
    // A load is taken only if every field is legal BCD within its limit.
    always_comb begin
        load_val.hh = hh_in;
        load_val.mm = mm_in;
        load_val.ss = ss_in;
        load_ok     = bcd_byte_ok(hh_in) && bcd_byte_ok(mm_in) && bcd_byte_ok(ss_in)
                      && (hh_in <= HH_MAX) && (mm_in <= BCD_59) && (ss_in <= BCD_59);
    end
`endif

    // Next-state, count and flag logic; priority load > ack > stop > start > tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        if (load) begin
            // A rejected load leaves everything untouched and still owns the cycle.
            if (load_ok) begin
                cnt_d   = load_val;
                state_d = IDLE;
                fin_d   = 1'b0;
            end
        end else if (ack) begin
            if (state_q == DONE) begin
                state_d = IDLE;
                fin_d   = 1'b0;
            end
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start) begin
            if ((state_q == IDLE && cnt_nonzero) || state_q == PAUSE) state_d = RUN;
        end else if (tick && state_q == RUN) begin
            cnt_d = dec_cnt;
            if (dec_cnt == '0) begin
                state_d = DONE;
                fin_d   = 1'b1;
            end
        end
        activo_d = (state_d == RUN);
    end

    // State, count and flag registers with asynchronous clear.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
            activo_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fin_q    <= fin_d;
            activo_q <= activo_d;
        end
    end

    assign hh        = cnt_q.hh;
    assign mm        = cnt_q.mm;
    assign ss        = cnt_q.ss;
    assign fin_crono = fin_q;
    assign activo    = activo_q;

endmodule

// File: tb/tb_cronometro_regresivo.sv
// Directed self-checking bench for cronometro_regresivo with an expectation queue.
module tb_cronometro_regresivo;

    logic       CLK;
    logic       reset;
    logic       tick_1hz, load, start, stop, ack;
    logic [7:0] hh_in, mm_in, ss_in;
    logic [7:0] hh, mm, ss;
    logic       fin_crono, activo;

    typedef struct {
        string      tag;
        logic [25:0] vec;  // {hh, mm, ss, fin_crono, activo}
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    cronometro_regresivo dut (
        .CLK       (CLK),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .load      (load),
        .start     (start),
        .stop      (stop),
        .ack       (ack),
        .hh_in     (hh_in),
        .mm_in     (mm_in),
        .ss_in     (ss_in),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .fin_crono (fin_crono),
        .activo    (activo)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Convert 0..99 to packed BCD.
    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push(input string tag, input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input logic f, input logic a);
        exp_t e;
        e.tag = tag;
        e.vec = {h, m, s, f, a};
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic [25:0] obs;
        e   = exp_q.pop_front();
        obs = {hh, mm, ss, fin_crono, activo};
        n_total++;
        assert (obs === e.vec) n_pass++;
        else $error("FAIL %s: observed hh:mm:ss=%h:%h:%h fin=%b act=%b, expected %h:%h:%h fin=%b act=%b",
                    e.tag, obs[25:18], obs[17:10], obs[9:2], obs[1], obs[0],
                    e.vec[25:18], e.vec[17:10], e.vec[9:2], e.vec[1], e.vec[0]);
    endtask

    // One clock with the given controls held, then sample 1 time unit after the edge.
    task automatic apply(input logic l, input logic st, input logic sp,
                         input logic a, input logic t);
        load = l; start = st; stop = sp; ack = a; tick_1hz = t;
        @(posedge CLK);
        #1;
        load = 0; start = 0; stop = 0; ack = 0; tick_1hz = 0;
        check_pop();
    endtask

    task automatic set_in(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hh_in = h; mm_in = m; ss_in = s;
    endtask

    initial begin
        int secs;
        reset = 1'b0;
        tick_1hz = 0; load = 0; start = 0; stop = 0; ack = 0;
        set_in(8'h00, 8'h00, 8'h00);
        #1;
        push("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check_pop();
        #11 reset = 1'b1;
        @(posedge CLK);
        #1;

        // One-minute countdown to expiry, then ticks in DONE.
        set_in(8'h00, 8'h01, 8'h00);
        push("load_0100", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
        push("start_0100", 8'h00, 8'h01, 8'h00, 1'b0, 1'b1); apply(0, 1, 0, 0, 0);
        push("tick_0059", 8'h00, 8'h00, 8'h59, 1'b0, 1'b1); apply(0, 0, 0, 0, 1);
        for (int i = 58; i >= 0; i--) begin
            secs = i;
            push($sformatf("tick_%0d", secs), 8'h00, 8'h00, to_bcd(secs),
                 (secs == 0), (secs != 0));
            apply(0, 0, 0, 0, 1);
        end
        for (int i = 0; i < 3; i++) begin
            push("done_tick", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); apply(0, 0, 0, 0, 1);
        end
        push("ack", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); apply(0, 0, 0, 1, 0);

        // Double borrow from one hour.
        set_in(8'h01, 8'h00, 8'h00);
        push("load_1h", 8'h01, 8'h00, 8'h00, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
        push("start_1h", 8'h01, 8'h00, 8'h00, 1'b0, 1'b1); apply(0, 1, 0, 0, 0);
        push("dbl_borrow", 8'h00, 8'h59, 8'h59, 1'b0, 1'b1); apply(0, 0, 0, 0, 1);
        push("stop_1h", 8'h00, 8'h59, 8'h59, 1'b0, 1'b0); apply(0, 0, 1, 0, 0);

        // Pause behaviour and stop+tick priority.
        set_in(8'h00, 8'h00, 8'h03);
        push("load_3", 8'h00, 8'h00, 8'h03, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
        push("start_3", 8'h00, 8'h00, 8'h03, 1'b0, 1'b1); apply(0, 1, 0, 0, 0);
        push("tick_2", 8'h00, 8'h00, 8'h02, 1'b0, 1'b1); apply(0, 0, 0, 0, 1);
        push("stop_tick", 8'h00, 8'h00, 8'h02, 1'b0, 1'b0); apply(0, 0, 1, 0, 1);
        push("pause_tick", 8'h00, 8'h00, 8'h02, 1'b0, 1'b0); apply(0, 0, 0, 0, 1);
        push("start_tick", 8'h00, 8'h00, 8'h02, 1'b0, 1'b1); apply(0, 1, 0, 0, 1);
        push("resume_1", 8'h00, 8'h00, 8'h01, 1'b0, 1'b1); apply(0, 0, 0, 0, 1);
        push("expire_3", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); apply(0, 0, 0, 0, 1);
        push("ack_3", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); apply(0, 0, 0, 1, 0);
        push("start_zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); apply(0, 1, 0, 0, 0);
        push("tick_zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); apply(0, 0, 0, 0, 1);

        // Second expiry cleared by a load instead of ack.
        set_in(8'h00, 8'h00, 8'h01);
        push("load_1", 8'h00, 8'h00, 8'h01, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
        push("start_1", 8'h00, 8'h00, 8'h01, 1'b0, 1'b1); apply(0, 1, 0, 0, 0);
        push("expire_1", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); apply(0, 0, 0, 0, 1);
        push("start_done", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); apply(0, 1, 0, 0, 0);
        set_in(8'h00, 8'h00, 8'h10);
        push("reload_10", 8'h00, 8'h00, 8'h10, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);

        // Out-of-range load.
        set_in(8'h24, 8'h61, 8'h05);
`ifdef CRONO_BCD_CLAMP_EN
        push("load_oor", 8'h23, 8'h59, 8'h05, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
        set_in(8'h00, 8'h00, 8'h7A);
        push("load_clamp_ss", 8'h00, 8'h00, 8'h59, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
`else
        push("load_oor", 8'h00, 8'h00, 8'h10, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
        set_in(8'h00, 8'h00, 8'h7A);
        push("load_bad_digit", 8'h00, 8'h00, 8'h10, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
`endif

        // Load beats tick while running, then asynchronous reset at 00:00:05.
        set_in(8'h00, 8'h00, 8'h07);
        push("load_7", 8'h00, 8'h00, 8'h07, 1'b0, 1'b0); apply(1, 0, 0, 0, 0);
        push("start_7", 8'h00, 8'h00, 8'h07, 1'b0, 1'b1); apply(0, 1, 0, 0, 0);
        push("tick_6", 8'h00, 8'h00, 8'h06, 1'b0, 1'b1); apply(0, 0, 0, 0, 1);
        set_in(8'h00, 8'h00, 8'h09);
        push("load_over_tick", 8'h00, 8'h00, 8'h09, 1'b0, 1'b0); apply(1, 0, 0, 0, 1);
        push("start_9", 8'h00, 8'h00, 8'h09, 1'b0, 1'b1); apply(0, 1, 0, 0, 0);
        for (int i = 8; i >= 5; i--) begin
            secs = i;
            push($sformatf("run_%0d", secs), 8'h00, 8'h00, to_bcd(secs), 1'b0, 1'b1);
            apply(0, 0, 0, 0, 1);
        end
        #2 reset = 1'b0;
        #1;
        push("async_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        check_pop();
        #2 reset = 1'b1;
        push("post_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); apply(0, 0, 0, 0, 1);
        push("post_reset_start", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); apply(0, 1, 0, 0, 0);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL queue_empty: observed %0d left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
